// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_arbiter
// Brief    : Shares a single-port synchronous RAM between a user port and a
//            periodic display scanner, with alternating-priority arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module ram_access_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 4,
    parameter int SCAN_DIV = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              usr_req,
    input  logic              usr_we,
    input  logic [ADDR_W-1:0] usr_addr,
    input  logic [DATA_W-1:0] usr_wdata,
    output logic              usr_ack,
    output logic [DATA_W-1:0] usr_rdata,
    output logic              usr_rvalid,
    input  logic              scan_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid
);

    localparam int                  c_TICK_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(SCAN_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_U_ACC  = 3'd1,
        ST_U_WAIT = 3'd2,
        ST_S_ACC  = 3'd3,
        ST_S_WAIT = 3'd4
    } state_t;

    state_t              r_state,        w_state_nxt;
    logic [c_TICK_W-1:0] r_tick;
    logic                r_scan_pending, w_scan_pending_nxt;
    logic [ADDR_W-1:0]   r_scan_ptr,     w_scan_ptr_nxt;
    logic                r_last_scan,    w_last_scan_nxt;
    logic [ADDR_W-1:0]   r_mem_addr,     w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata,    w_mem_wdata_nxt;
    logic                r_mem_we,       w_mem_we_nxt;
    logic                r_usr_ack,      w_usr_ack_nxt;
    logic [DATA_W-1:0]   r_usr_rdata,    w_usr_rdata_nxt;
    logic                r_usr_rvalid,   w_usr_rvalid_nxt;
    logic [ADDR_W-1:0]   r_disp_addr,    w_disp_addr_nxt;
    logic [DATA_W-1:0]   r_disp_data,    w_disp_data_nxt;
    logic                r_disp_valid,   w_disp_valid_nxt;

    logic w_tick_wrap;
    logic w_scan_req;
    logic w_grant_usr;
    logic w_grant_scan;

    assign w_tick_wrap  = scan_en && (r_tick == c_TICK_MAX);
    // Disabling the scanner also cancels a scan that is pending but not yet granted.
    assign w_scan_req   = r_scan_pending && scan_en;
    assign w_grant_usr  = usr_req && (!w_scan_req || r_last_scan);
    assign w_grant_scan = w_scan_req && (!usr_req || !r_last_scan);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= '0;
        end else if (!scan_en || w_tick_wrap) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_scan_pending_nxt = r_scan_pending;
        w_scan_ptr_nxt     = r_scan_ptr;
        w_last_scan_nxt    = r_last_scan;
        w_mem_addr_nxt     = r_mem_addr;
        w_mem_wdata_nxt    = r_mem_wdata;
        w_mem_we_nxt       = 1'b0;
        w_usr_ack_nxt      = 1'b0;
        w_usr_rdata_nxt    = r_usr_rdata;
        w_usr_rvalid_nxt   = 1'b0;
        w_disp_addr_nxt    = r_disp_addr;
        w_disp_data_nxt    = r_disp_data;
        w_disp_valid_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_usr) begin
                    w_state_nxt     = ST_U_ACC;
                    w_mem_addr_nxt  = usr_addr;
                    w_mem_wdata_nxt = usr_wdata;
                    w_mem_we_nxt    = usr_we;
                    w_usr_ack_nxt   = 1'b1;
                    w_last_scan_nxt = 1'b0;
                end else if (w_grant_scan) begin
                    w_state_nxt        = ST_S_ACC;
                    w_mem_addr_nxt     = r_scan_ptr;
                    w_last_scan_nxt    = 1'b1;
                    w_scan_pending_nxt = 1'b0;
                end
            end
            ST_U_ACC: begin
                if (r_mem_we) begin
                    w_state_nxt = ST_IDLE;
                    // Keep the display coherent with a write to the word it shows.
                    if (r_mem_addr == r_disp_addr) begin
                        w_disp_data_nxt  = r_mem_wdata;
                        w_disp_valid_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_U_WAIT;
                end
            end
            ST_U_WAIT: begin
                w_state_nxt      = ST_IDLE;
                w_usr_rdata_nxt  = mem_rdata;
                w_usr_rvalid_nxt = 1'b1;
            end
            ST_S_ACC: begin
                w_state_nxt = ST_S_WAIT;
            end
            ST_S_WAIT: begin
                w_state_nxt      = ST_IDLE;
                w_disp_addr_nxt  = r_scan_ptr;
                w_disp_data_nxt  = mem_rdata;
                w_disp_valid_nxt = 1'b1;
                w_scan_ptr_nxt   = r_scan_ptr + 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A tick on the grant edge survives so it is not lost.
        if (!scan_en) begin
            w_scan_pending_nxt = 1'b0;
        end else if (w_tick_wrap) begin
            w_scan_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_scan_pending <= 1'b0;
            r_scan_ptr     <= '0;
            r_last_scan    <= 1'b1;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_we       <= 1'b0;
            r_usr_ack      <= 1'b0;
            r_usr_rdata    <= '0;
            r_usr_rvalid   <= 1'b0;
            r_disp_addr    <= '0;
            r_disp_data    <= '0;
            r_disp_valid   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_scan_pending <= w_scan_pending_nxt;
            r_scan_ptr     <= w_scan_ptr_nxt;
            r_last_scan    <= w_last_scan_nxt;
            r_mem_addr     <= w_mem_addr_nxt;
            r_mem_wdata    <= w_mem_wdata_nxt;
            r_mem_we       <= w_mem_we_nxt;
            r_usr_ack      <= w_usr_ack_nxt;
            r_usr_rdata    <= w_usr_rdata_nxt;
            r_usr_rvalid   <= w_usr_rvalid_nxt;
            r_disp_addr    <= w_disp_addr_nxt;
            r_disp_data    <= w_disp_data_nxt;
            r_disp_valid   <= w_disp_valid_nxt;
        end
    end

    assign usr_ack    = r_usr_ack;
    assign usr_rdata  = r_usr_rdata;
    assign usr_rvalid = r_usr_rvalid;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;
    assign disp_addr  = r_disp_addr;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_access_arbiter
// Brief    : Directed self-checking bench for ram_access_arbiter with RAM models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_access_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         checks = 0;
    int         failures = 0;

    // Instance A: SCAN_DIV=4
    logic       usr_req = 0, usr_we = 0, scan_en = 0, load = 0;
    logic [4:0] usr_addr = '0;
    logic [3:0] usr_wdata = '0;
    logic       usr_ack, usr_rvalid, mem_we, disp_valid;
    logic [3:0] usr_rdata, mem_wdata, disp_data;
    logic [3:0] mem_rdata = '0;
    logic [4:0] mem_addr, disp_addr;
    logic [3:0] ram [32];

    // Instance B: SCAN_DIV=1
    logic       usr_req_b = 0, usr_we_b = 0, scan_en_b = 0, load_b = 0;
    logic [4:0] usr_addr_b = '0;
    logic [3:0] usr_wdata_b = '0;
    logic       usr_ack_b, usr_rvalid_b, mem_we_b, disp_valid_b;
    logic [3:0] usr_rdata_b, mem_wdata_b, disp_data_b;
    logic [3:0] mem_rdata_b = '0;
    logic [4:0] mem_addr_b, disp_addr_b;
    logic [3:0] ram_b [32];

    always #5 clk = ~clk;

    ram_access_arbiter #(.ADDR_W(5), .DATA_W(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
        .usr_ack(usr_ack), .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid),
        .scan_en(scan_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid)
    );

    ram_access_arbiter #(.ADDR_W(5), .DATA_W(4), .SCAN_DIV(1)) dut_b (
        .clk(clk), .rst(rst),
        .usr_req(usr_req_b), .usr_we(usr_we_b), .usr_addr(usr_addr_b), .usr_wdata(usr_wdata_b),
        .usr_ack(usr_ack_b), .usr_rdata(usr_rdata_b), .usr_rvalid(usr_rvalid_b),
        .scan_en(scan_en_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_rdata(mem_rdata_b),
        .disp_addr(disp_addr_b), .disp_data(disp_data_b), .disp_valid(disp_valid_b)
    );

    // Synchronous read-first RAMs; load presets word i to i mod 16 (A) or 3*i mod 16 (B).
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 32; i++) ram[i] <= 4'(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    always @(posedge clk) begin
        if (load_b) begin
            for (int i = 0; i < 32; i++) ram_b[i] <= 4'(i * 3);
        end else if (mem_we_b) begin
            ram_b[mem_addr_b] <= mem_wdata_b;
        end
        mem_rdata_b <= ram_b[mem_addr_b];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [4:0] addr, input logic [3:0] data);
        usr_we = we; usr_addr = addr; usr_wdata = data; usr_req = 1'b1;
        step();
        usr_req = 1'b0;
    endtask

    task automatic test_reset();
        load = 1'b1; load_b = 1'b1;
        step(); step();
        load = 1'b0; load_b = 1'b0;
        rst = 1'b0;
        step();
        checks++; if ({usr_ack, usr_rdata, usr_rvalid, mem_addr, mem_wdata, mem_we, disp_addr, disp_data, disp_valid} !== 31'd0) begin
            failures++; $display("FAIL reset_a: outputs=%h expected 0", {usr_ack, usr_rdata, usr_rvalid, mem_addr, mem_wdata, mem_we, disp_addr, disp_data, disp_valid}); end
        checks++; if ({usr_ack_b, usr_rdata_b, usr_rvalid_b, mem_addr_b, mem_wdata_b, mem_we_b, disp_addr_b, disp_data_b, disp_valid_b} !== 31'd0) begin
            failures++; $display("FAIL reset_b: outputs=%h expected 0", {usr_ack_b, usr_rdata_b, usr_rvalid_b, mem_addr_b, mem_wdata_b, mem_we_b, disp_addr_b, disp_data_b, disp_valid_b}); end
    endtask

    task automatic test_write();
        issue(1'b1, 5'd5, 4'hA);
        checks++; if (usr_ack !== 1'b1) begin failures++; $display("FAIL wr_ack: got %b expected 1", usr_ack); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL wr_we: got %b expected 1", mem_we); end
        checks++; if (mem_addr !== 5'd5) begin failures++; $display("FAIL wr_addr: got %0d expected 5", mem_addr); end
        checks++; if (mem_wdata !== 4'hA) begin failures++; $display("FAIL wr_wdata: got %h expected a", mem_wdata); end
        step();
        checks++; if (usr_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_pulse: got %b expected 0", usr_ack); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL wr_we_pulse: got %b expected 0", mem_we); end
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL wr_no_disp: got %b expected 0", disp_valid); end
        step();
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL wr_we_after: got %b expected 0", mem_we); end
        checks++; if (ram[5] !== 4'hA) begin failures++; $display("FAIL wr_ram: got %h expected a", ram[5]); end
    endtask

    task automatic test_read();
        issue(1'b0, 5'd5, 4'h0);
        checks++; if (usr_ack !== 1'b1) begin failures++; $display("FAIL rd_ack: got %b expected 1", usr_ack); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rd_we0: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 5'd5) begin failures++; $display("FAIL rd_addr: got %0d expected 5", mem_addr); end
        step();
        checks++; if (usr_rvalid !== 1'b0) begin failures++; $display("FAIL rd_early_valid: got %b expected 0", usr_rvalid); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rd_we1: got %b expected 0", mem_we); end
        step();
        checks++; if (usr_rvalid !== 1'b1) begin failures++; $display("FAIL rd_valid: got %b expected 1", usr_rvalid); end
        checks++; if (usr_rdata !== 4'hA) begin failures++; $display("FAIL rd_data: got %h expected a", usr_rdata); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rd_we2: got %b expected 0", mem_we); end
        step();
        checks++; if (usr_rvalid !== 1'b0) begin failures++; $display("FAIL rd_valid_pulse: got %b expected 0", usr_rvalid); end
        checks++; if (usr_rdata !== 4'hA) begin failures++; $display("FAIL rd_data_hold: got %h expected a", usr_rdata); end
    endtask

    task automatic test_scan();
        int n;
        load = 1'b1; step(); load = 1'b0;
        scan_en = 1'b1;
        for (int k = 0; k < 33; k++) begin
            step(); n = 1;
            while (disp_valid !== 1'b1 && n < 20) begin step(); n++; end
            checks++; if (disp_valid !== 1'b1) begin failures++; $display("FAIL scan_timeout k=%0d: disp_valid=%b expected 1", k, disp_valid); end
            checks++; if (disp_addr !== 5'(k)) begin failures++; $display("FAIL scan_addr k=%0d: got %0d expected %0d", k, disp_addr, 5'(k)); end
            checks++; if (disp_data !== 4'(k)) begin failures++; $display("FAIL scan_data k=%0d: got %h expected %h", k, disp_data, 4'(k)); end
        end
        scan_en = 1'b0;
        step();
    endtask

    task automatic test_writethrough();
        int n;
        issue(1'b1, 5'd7, 4'h3);
        step();
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL wt_other_addr: disp_valid=%b expected 0", disp_valid); end
        scan_en = 1'b1;
        step(); n = 1;
        while (!(disp_valid === 1'b1 && disp_addr === 5'd7) && n < 100) begin step(); n++; end
        scan_en = 1'b0;
        checks++; if (disp_addr !== 5'd7) begin failures++; $display("FAIL wt_reach7: disp_addr=%0d expected 7", disp_addr); end
        checks++; if (disp_data !== 4'h3) begin failures++; $display("FAIL wt_show3: got %h expected 3", disp_data); end
        step(); step();
        checks++; if (disp_addr !== 5'd7) begin failures++; $display("FAIL wt_hold7: disp_addr=%0d expected 7", disp_addr); end
        issue(1'b1, 5'd7, 4'hC);
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL wt_e0: disp_valid=%b expected 0", disp_valid); end
        step();
        checks++; if (disp_valid !== 1'b1) begin failures++; $display("FAIL wt_valid: got %b expected 1", disp_valid); end
        checks++; if (disp_data !== 4'hC) begin failures++; $display("FAIL wt_data: got %h expected c", disp_data); end
        checks++; if (disp_addr !== 5'd7) begin failures++; $display("FAIL wt_addr: got %0d expected 7", disp_addr); end
        step();
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL wt_pulse: got %b expected 0", disp_valid); end
        issue(1'b1, 5'd8, 4'h5);
        step();
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL wt8_valid: got %b expected 0", disp_valid); end
        checks++; if (disp_data !== 4'hC) begin failures++; $display("FAIL wt8_data: got %h expected c", disp_data); end
        step();
    endtask

    task automatic test_reset_midread();
        issue(1'b0, 5'd5, 4'h0);
        checks++; if (usr_ack !== 1'b1) begin failures++; $display("FAIL mr_ack: got %b expected 1", usr_ack); end
        step();
        #2 rst = 1'b1;
        #1;
        checks++; if ({usr_ack, usr_rdata, usr_rvalid, mem_addr, mem_wdata, mem_we, disp_addr, disp_data, disp_valid} !== 31'd0) begin
            failures++; $display("FAIL mr_async_clear: outputs=%h expected 0", {usr_ack, usr_rdata, usr_rvalid, mem_addr, mem_wdata, mem_we, disp_addr, disp_data, disp_valid}); end
        step();
        checks++; if (usr_rvalid !== 1'b0) begin failures++; $display("FAIL mr_no_rvalid: got %b expected 0", usr_rvalid); end
        rst = 1'b0;
        scan_en = 1'b1;
        repeat (4) step();
        usr_we = 1'b0; usr_addr = 5'd5; usr_req = 1'b1;
        step();
        usr_req = 1'b0;
        checks++; if (usr_ack !== 1'b1) begin failures++; $display("FAIL tie_user_first: usr_ack=%b expected 1", usr_ack); end
        step(); step();
        checks++; if (usr_rvalid !== 1'b1) begin failures++; $display("FAIL tie_rvalid: got %b expected 1", usr_rvalid); end
        checks++; if (usr_rdata !== 4'h5) begin failures++; $display("FAIL tie_rdata: got %h expected 5", usr_rdata); end
        step(); step(); step();
        checks++; if (disp_valid !== 1'b1) begin failures++; $display("FAIL tie_scan_next: disp_valid=%b expected 1", disp_valid); end
        checks++; if (disp_addr !== 5'd0) begin failures++; $display("FAIL tie_scan_addr: got %0d expected 0", disp_addr); end
        scan_en = 1'b0;
        step();
    endtask

    task automatic test_alternation();
        int k;
        usr_we_b = 1'b0; usr_addr_b = 5'd9; usr_req_b = 1'b1; scan_en_b = 1'b1;
        k = 0;
        for (int c = 1; c <= 24; c++) begin
            step();
            checks++; if (usr_ack_b !== (c % 6 == 1)) begin failures++; $display("FAIL alt_ack c=%0d: got %b expected %b", c, usr_ack_b, (c % 6 == 1)); end
            checks++; if (usr_rvalid_b !== (c % 6 == 3)) begin failures++; $display("FAIL alt_rvalid c=%0d: got %b expected %b", c, usr_rvalid_b, (c % 6 == 3)); end
            checks++; if (disp_valid_b !== (c % 6 == 0)) begin failures++; $display("FAIL alt_disp c=%0d: got %b expected %b", c, disp_valid_b, (c % 6 == 0)); end
            checks++; if (mem_we_b !== 1'b0) begin failures++; $display("FAIL alt_we c=%0d: got %b expected 0", c, mem_we_b); end
            if (c % 6 == 3) begin
                checks++; if (usr_rdata_b !== 4'hB) begin failures++; $display("FAIL alt_rdata c=%0d: got %h expected b", c, usr_rdata_b); end
            end
            if (c % 6 == 0) begin
                checks++; if (disp_addr_b !== 5'(k)) begin failures++; $display("FAIL alt_daddr c=%0d: got %0d expected %0d", c, disp_addr_b, k); end
                checks++; if (disp_data_b !== 4'(k * 3)) begin failures++; $display("FAIL alt_ddata c=%0d: got %h expected %h", c, disp_data_b, 4'(k * 3)); end
                k++;
            end
        end
        usr_req_b = 1'b0; scan_en_b = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_scan();
        test_writethrough();
        test_reset_midread();
        test_alternation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Sequences and shares the single-port 32x4 synchronous RAM between two requesters:
  - a user port driven from the switch/key front end (write or read);
  - an internal auto-scanner that periodically reads successive addresses for the HEX display path.
- Owns every RAM control signal; the RAM has no other master.
- Provides fair alternating arbitration, fixed-latency access sequencing and write-through coherency of the displayed word.

Parameters:
- ADDR_W, 5, RAM address width (32 words).
- DATA_W, 4, RAM data width.
- SCAN_DIV, 50000000, clk cycles between scan ticks (1 s at 50 MHz); legal minimum is 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- usr_req  in  1  user access request, level; held until usr_ack.
- usr_we  in  1  1=write, 0=read; sampled with usr_req.
- usr_addr  in  ADDR_W  user address.
- usr_wdata  in  DATA_W  user write data.
- usr_ack  out  1  one-cycle pulse: request granted and issued to RAM.
- usr_rdata  out  DATA_W  read result, held until next user read.
- usr_rvalid  out  1  one-cycle pulse: usr_rdata updated.
- scan_en  in  1  enables periodic scanning.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM registered read data; valid one edge after address is sampled.
- disp_addr  out  ADDR_W  address of displayed word.
- disp_data  out  DATA_W  displayed word.
- disp_valid  out  1  one-cycle pulse: disp_addr/disp_data updated.

Behaviour:
- Reset (async):
  - all outputs 0; state IDLE; tick counter 0; scan_ptr 0; scan_pending 0.
  - last_grant = SCAN, so the user wins the first tie.
- All outputs are registered; no combinational path from inputs to outputs.
- Tick counter:
  - when scan_en=1, counts 0..SCAN_DIV-1 and wraps; the wrap cycle sets scan_pending.
  - when scan_en=0, counter is forced to 0 and scan_pending is cleared.
  - a scan already in S_ACC/S_WAIT still completes.
  - ticks arriving while scan_pending=1 collapse into one pending scan; there is no queue.
- FSM states: IDLE, U_ACC, U_WAIT, S_ACC, S_WAIT.
- IDLE grant rules:
  - only usr_req: grant user.
  - only scan_pending: grant scan.
  - both: grant the one not equal to last_grant.
  - granting updates last_grant.
- User grant, request sampled at edge E0:
  - after E0: state U_ACC; mem_addr=usr_addr; mem_wdata=usr_wdata; mem_we=usr_we; usr_ack=1.
  - mem_we is high for exactly this one cycle.
  - write: RAM stores at E1; state returns to IDLE at E1.
  - read: U_WAIT after E1; at E2, usr_rdata<=mem_rdata and usr_rvalid pulses for one cycle; state returns to IDLE.
  - usr_req is ignored in every non-IDLE state.
  - a requester that still holds usr_req after usr_ack is re-granted on the next IDLE cycle.
- Scan grant:
  - S_ACC: mem_addr=scan_ptr, mem_we=0; scan_pending cleared.
  - S_WAIT: at the next edge, disp_addr<=scan_ptr, disp_data<=mem_rdata, disp_valid pulses.
  - scan_ptr increments modulo 2^ADDR_W (31 wraps to 0).
- Access occupancy: write = 1 busy cycle; read or scan = 2 busy cycles. Each access is followed by at least one IDLE cycle.
- Write-through coherency: a user write with usr_addr==disp_addr updates disp_data<=usr_wdata at E1 and pulses disp_valid.
- mem_we is 0 in every state except a U_ACC write.
- Reset asserted mid-access aborts the access immediately and returns everything to reset values. A write already issued at the reset edge is not guaranteed.
- SCAN_DIV=1: a tick occurs every cycle; scan and user accesses strictly alternate under continuous usr_req.

Test Plan:
- Reset, scan_en=0; write addr 5 data 0xA (usr_req held 1 cycle) -> usr_ack next cycle, mem_we high exactly 1 cycle with mem_addr=5, mem_wdata=0xA.
- Write addr 5 = 0xA, then read addr 5 -> usr_rvalid pulse 2 cycles after usr_ack, usr_rdata=0xA; mem_we=0 throughout the read.
- SCAN_DIV=4, scan_en=1, RAM preloaded with word i = i mod 16 -> disp_valid every scan with disp_addr 0,1,2…31,0, disp_data matching; wrap 31->0 checked.
- SCAN_DIV=1, usr_req held high with reads -> grants alternate user/scan/user; no starvation; every usr_ack followed by usr_rvalid.
- disp_addr=7 showing 0x3; user writes 0xC to addr 7 -> disp_data=0xC with disp_valid at the write edge; write to addr 8 leaves disp_data unchanged.
- Assert rst during U_WAIT of a read -> all outputs 0 asynchronously, no usr_rvalid; after release, the first tie is granted to the user.
